// File: rtl/clkdiv_pkg.sv
// Shared constants, level conversion and output-mode type for the clock divider.
// Thresholds and levels are kept in millivolts and scaled to the sample format where used.
package clkdiv_pkg;

  localparam int SCHMITT_HI = 2000;
  localparam int SCHMITT_LO = 500;
  localparam int OUT_HI     = 5000;
  localparam int OUT_LO     = 0;

  typedef enum logic {
    MODE_GATE = 1'b0,
    MODE_TRIG = 1'b1
  } out_mode_t;

  function automatic int FROM_MV(input int mv, input int fp_offset);
    return mv * (1 << fp_offset);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: phase counter, trigger timer and registered output level.
// All state advances only on strobe; the output reflects the post-strobe state.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV       = 1,
  parameter int DIV_WIDTH = 8,
  parameter int TRIG_LEN  = 48,
  parameter int W         = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      strobe,
  input  logic      clk_edge,
  input  logic      rst_edge,
  input  logic      in0_state,
  input  out_mode_t mode,
  output logic      out_hi
);

  localparam int TW = $clog2(TRIG_LEN + 1);
  localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(DIV - 1);
  localparam logic [DIV_WIDTH-1:0] HALF = DIV_WIDTH'((DIV + 1) / 2);

  if (DIV < 1 || DIV > (1 << DIV_WIDTH) - 1) begin : g_bad_div
    $error("clkdiv_channel: DIV must be in 1..2^DIV_WIDTH-1");
  end
  if (TRIG_LEN < 1 || W < 2) begin : g_bad_trig
    $error("clkdiv_channel: TRIG_LEN must be at least 1");
  end

  logic [DIV_WIDTH-1:0] count, count_next;
  logic [TW-1:0]        timer, timer_next;
  logic                 phase0;
  logic                 level;

  // Reset edge wins over a coincident clock edge, which then lands on phase 0.
  always_comb begin
    count_next = count;
    timer_next = timer;
    phase0     = 1'b0;
    if (strobe) begin
      if (rst_edge && clk_edge) begin
        count_next = '0;
        phase0     = 1'b1;
      end else if (rst_edge) begin
        count_next = LAST;
      end else if (clk_edge) begin
        phase0     = (count == LAST);
        count_next = (count == LAST) ? '0 : count + 1'b1;
      end
      if (phase0) begin
        timer_next = TW'(TRIG_LEN);
      end else if (timer != '0) begin
        timer_next = timer - 1'b1;
      end
    end
  end

  always_comb begin
    level = 1'b0;
    if (mode == MODE_TRIG) begin
      level = (timer_next != '0);
    end else if (DIV == 1) begin
      level = in0_state;
    end else begin
      level = (count_next < HALF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= LAST;
      timer  <= '0;
      out_hi <= 1'b0;
    end else begin
      count <= count_next;
      timer <= timer_next;
      if (strobe) begin
        out_hi <= level;
      end
    end
  end

endmodule

// File: rtl/clkdiv_ratio.sv
// Four-output eurorack clock divider: Schmitt inputs, reset synchroniser and four channels.
// in0 is the clock, in1 re-phases all dividers, in2 selects gate or trigger outputs.
module clkdiv_ratio
  import clkdiv_pkg::*;
#(
  parameter int W         = 16,
  parameter int FP_OFFSET = 2,
  parameter int DIV_WIDTH = 8,
  parameter int DIV0      = 1,
  parameter int DIV1      = 2,
  parameter int DIV2      = 4,
  parameter int DIV3      = 8,
  parameter int TRIG_LEN  = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_strobe,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3
);

  localparam logic signed [W-1:0] TH_HI  = W'(FROM_MV(SCHMITT_HI, FP_OFFSET));
  localparam logic signed [W-1:0] TH_LO  = W'(FROM_MV(SCHMITT_LO, FP_OFFSET));
  localparam logic signed [W-1:0] LVL_HI = W'(FROM_MV(OUT_HI, FP_OFFSET));
  localparam logic signed [W-1:0] LVL_LO = W'(FROM_MV(OUT_LO, FP_OFFSET));

  function automatic int div_of(input int k);
    case (k)
      0:       return DIV0;
      1:       return DIV1;
      2:       return DIV2;
      default: return DIV3;
    endcase
  endfunction

  logic [1:0]          rst_sync;
  logic                strobe;
  logic signed [W-1:0] smp [3];
  logic [2:0]          st, st_next, rise;
  logic [3:0]          hi;
  out_mode_t           mode;
  logic                unused_in3;

  assign unused_in3 = ^sample_in3;
  assign smp[0]     = sample_in0;
  assign smp[1]     = sample_in1;
  assign smp[2]     = sample_in2;

  // Strobes are held off until reset release has passed through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign strobe = sample_strobe & rst_sync[1];

  always_comb begin
    st_next = st;
    if (strobe) begin
      for (int i = 0; i < 3; i++) begin
        if (smp[i] > TH_HI) begin
          st_next[i] = 1'b1;
        end else if (smp[i] < TH_LO) begin
          st_next[i] = 1'b0;
        end
      end
    end
  end

  assign rise = st_next & ~st;
  assign mode = st_next[2] ? MODE_TRIG : MODE_GATE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
    end else begin
      st <= st_next;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_ch
    clkdiv_channel #(
      .DIV       (div_of(k)),
      .DIV_WIDTH (DIV_WIDTH),
      .TRIG_LEN  (TRIG_LEN),
      .W         (W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .strobe    (strobe),
      .clk_edge  (rise[0]),
      .rst_edge  (rise[1]),
      .in0_state (st_next[0]),
      .mode      (mode),
      .out_hi    (hi[k])
    );
  end

  assign sample_out0 = hi[0] ? LVL_HI : LVL_LO;
  assign sample_out1 = hi[1] ? LVL_HI : LVL_LO;
  assign sample_out2 = hi[2] ? LVL_HI : LVL_LO;
  assign sample_out3 = hi[3] ? LVL_HI : LVL_LO;

endmodule

// File: tb/tb_clkdiv_ratio.sv
// Directed bench for clkdiv_ratio: a default instance and one with DIV1=3, TRIG_LEN=4,
// both checked against an edge-index model through a scoreboard queue.
module tb_clkdiv_ratio;

  localparam int W     = 16;
  localparam int LV_HI = 5000 * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_strobe = 1'b0;
  logic signed [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic signed [W-1:0] a_out [4];
  logic signed [W-1:0] b_out [4];

  int tests = 0;
  int fails = 0;

  int div_cfg [2][4] = '{'{1, 2, 4, 8}, '{1, 3, 4, 8}};
  int trig_cfg [2]   = '{48, 4};
  bit m_st0, m_st1, m_st2;
  int edge_idx;
  int since [2][4];

  logic [8*W-1:0] sb_q [$];
  string          tag_q [$];

  always #5 clk = ~clk;

  clkdiv_ratio u_dut_a (
    .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe),
    .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
    .sample_out0(a_out[0]), .sample_out1(a_out[1]),
    .sample_out2(a_out[2]), .sample_out3(a_out[3])
  );

  clkdiv_ratio #(.DIV1(3), .TRIG_LEN(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe),
    .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
    .sample_out0(b_out[0]), .sample_out1(b_out[1]),
    .sample_out2(b_out[2]), .sample_out3(b_out[3])
  );

  function automatic bit schmitt(input bit cur, input int mv);
    if (mv > 2000) return 1'b1;
    if (mv < 500)  return 1'b0;
    return cur;
  endfunction

  task automatic modelReset();
    m_st0 = 0; m_st1 = 0; m_st2 = 0;
    edge_idx = -1;
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++)
        since[n][k] = trig_cfg[n];
  endtask

  // edge_idx counts in0 edges since the last re-phase; -1 means the next edge is phase 0.
  task automatic modelStep(input int mv0, input int mv1, input int mv2);
    bit n0, n1, r0, r1, p0;
    n0 = schmitt(m_st0, mv0);
    n1 = schmitt(m_st1, mv1);
    r0 = n0 && !m_st0;
    r1 = n1 && !m_st1;
    if (r1 && r0)  edge_idx = 0;
    else if (r1)   edge_idx = -1;
    else if (r0)   edge_idx++;
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++) begin
        p0 = r0 && (edge_idx >= 0) && ((edge_idx % div_cfg[n][k]) == 0);
        if (p0) since[n][k] = 0;
        else if (since[n][k] < trig_cfg[n]) since[n][k]++;
      end
    m_st0 = n0;
    m_st1 = n1;
    m_st2 = schmitt(m_st2, mv2);
  endtask

  task automatic pushExpected(input string tag);
    logic [8*W-1:0] e;
    int d, ph;
    bit h;
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++) begin
        d = div_cfg[n][k];
        if (m_st2) h = since[n][k] < trig_cfg[n];
        else if (d == 1) h = m_st0;
        else begin
          ph = (edge_idx < 0) ? d - 1 : edge_idx % d;
          h  = ph < (d + 1) / 2;
        end
        e[(n*4+k)*W +: W] = h ? W'(LV_HI) : '0;
      end
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic applyStimulus(input string tag, input int mv0, input int mv1, input int mv2);
    @(negedge clk);
    in0 = W'(mv0 * 4);
    in1 = W'(mv1 * 4);
    in2 = W'(mv2 * 4);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    if (rst_n) modelStep(mv0, mv1, mv2);
    pushExpected(tag);
  endtask

  task automatic checkOutput();
    logic [8*W-1:0] e;
    logic signed [W-1:0] obs, ex;
    string t;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      obs = (i < 4) ? a_out[i] : b_out[i-4];
      ex  = e[i*W +: W];
      tests++;
      assert (obs === ex) else begin
        fails++;
        $error("[TB] FAIL %s dut_%s.out%0d observed=%0d expected=%0d",
               t, (i < 4) ? "a" : "b", i % 4, obs, ex);
      end
    end
  endtask

  task automatic step(input string tag, input int mv0, input int mv1, input int mv2);
    applyStimulus(tag, mv0, mv1, mv2);
    checkOutput();
  endtask

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    step("in_reset_lo", 0, 0, 0);
    step("in_reset_ignore", 3000, 3000, 3000);
    step("in_reset_ignore2", 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    step("post_reset_lo", 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      step("poweron_hi", 3000, 0, 0);
      step("poweron_lo", 0, 0, 0);
    end

    step("hyst_0", 0, 0, 0);
    step("hyst_1500", 1500, 0, 0);
    step("hyst_2100a", 2100, 0, 0);
    step("hyst_1000", 1000, 0, 0);
    step("hyst_2100b", 2100, 0, 0);
    step("hyst_400", 400, 0, 0);
    step("hyst_2100c", 2100, 0, 0);
    step("hyst_end", 0, 0, 0);

    for (int i = 0; i < 9; i++) begin
      step("odd_hi", 3000, 0, 0);
      step("odd_lo", 0, 0, 0);
    end

    for (int i = 0; i < 3; i++) begin
      step("pre_rst_hi", 3000, 0, 0);
      step("pre_rst_lo", 0, 0, 0);
    end
    step("rst_edge", 0, 3000, 0);
    step("rst_release", 0, 0, 0);
    step("after_rst_phase0", 3000, 0, 0);
    step("after_rst_lo", 0, 0, 0);
    step("edge_b", 3000, 0, 0);
    step("edge_b_lo", 0, 0, 0);
    step("simul_edges", 3000, 3000, 0);
    step("simul_release", 0, 0, 0);

    step("trig_enter", 0, 0, 3000);
    for (int i = 0; i < 12; i++) begin
      step("trig_hi", 3000, 0, 3000);
      step("trig_lo", 0, 0, 3000);
    end
    step("trig_idle1", 0, 0, 3000);
    step("trig_idle2", 0, 0, 3000);
    step("trig_pulse", 3000, 0, 3000);
    step("trig_pulse_lo", 0, 0, 3000);

    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    #1;
    pushExpected("async_reset_lo");
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    step("post_async_lo", 0, 0, 0);
    step("post_async_phase0", 3000, 0, 3000);
    for (int i = 0; i < 4; i++) begin
      step("post_async_lo_n", 0, 0, 3000);
      step("post_async_hi_n", 3000, 0, 3000);
    end
    step("gate_back", 0, 0, 0);
    step("gate_back_hi", 3000, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
